sb_tx_packet_framer: RTL and testbench

- Sideband transmit-side framer; the transmit counterpart of the sideband RX decode path.
- Accepts LTSM message requests and RDI message requests, plus SBINIT start-pattern requests.
- Builds 64-bit sideband header words, with an optional 64-bit data word, and computes parity.
- Presents each word to the sideband serializer with a valid/done handshake, then enforces an idle gap between packets.

---
 rtl/sb_tx_pkg.sv | 34 +++
 rtl/sb_tx_header_encoder.sv | 38 +++
 rtl/sb_tx_packet_framer.sv | 207 ++++++++++++++++++++
 tb/tb_sb_tx_packet_framer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_tx_pkg.sv
// Shared definitions for the sideband transmit framer: FSM states, opcodes,
// header field positions and the parity helper used for CP/DP.
package sb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PATTERN = 3'd1,
    ST_HEADER  = 3'd2,
    ST_DATA    = 3'd3,
    ST_GAP     = 3'd4
  } sb_tx_state_e;

  localparam logic [4:0] SB_OPC_MSG_NODATA = 5'b10010;
  localparam logic [4:0] SB_OPC_MSG_DATA64 = 5'b11011;
  localparam logic [7:0] SB_MSGCODE_LTSM   = 8'h85;

  // Header field positions (LSB and width of each field)
  localparam int unsigned SB_HDR_OPC_LSB  = 0;
  localparam int unsigned SB_HDR_OPC_W    = 5;
  localparam int unsigned SB_HDR_CODE_LSB = 14;
  localparam int unsigned SB_HDR_CODE_W   = 8;
  localparam int unsigned SB_HDR_SUB_LSB  = 32;
  localparam int unsigned SB_HDR_SUB_W    = 8;
  localparam int unsigned SB_HDR_INFO_LSB = 40;
  localparam int unsigned SB_HDR_INFO_W   = 16;
  localparam int unsigned SB_HDR_CP_BIT   = 62;
  localparam int unsigned SB_HDR_DP_BIT   = 63;

  // Even parity (XOR reduction) of a 64-bit word
  function automatic logic sb_parity(input logic [63:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/sb_tx_header_encoder.sv
// Combinational sideband header packer. Places opcode and message fields,
// then derives DP from the payload and CP over the rest of the header.
module sb_tx_header_encoder
  import sb_tx_pkg::*;
(
  input  logic        i_has_data,
  input  logic [7:0]  i_msg_code,
  input  logic [7:0]  i_msg_subcode,
  input  logic [15:0] i_msg_info,
  input  logic [63:0] i_payload,
  output logic [63:0] o_header
);

  logic [63:0] body;
  logic        dp;
  logic        cp;

  // Pack the field bits; reserved bits and both parity bits stay zero here
  always_comb begin
    body = '0;
    body[SB_HDR_OPC_LSB  +: SB_HDR_OPC_W]  = i_has_data ? SB_OPC_MSG_DATA64 : SB_OPC_MSG_NODATA;
    body[SB_HDR_CODE_LSB +: SB_HDR_CODE_W] = i_msg_code;
    body[SB_HDR_SUB_LSB  +: SB_HDR_SUB_W]  = i_msg_subcode;
    body[SB_HDR_INFO_LSB +: SB_HDR_INFO_W] = i_msg_info;
  end

  // DP covers the payload only; CP covers [61:0] plus DP
  assign dp = i_has_data ? sb_parity(i_payload) : 1'b0;
  assign cp = sb_parity(body) ^ dp;

  // Insert the parity bits into the final header
  always_comb begin
    o_header                = body;
    o_header[SB_HDR_CP_BIT] = cp;
    o_header[SB_HDR_DP_BIT] = dp;
  end

endmodule

// File: rtl/sb_tx_packet_framer.sv
// Sideband TX framer: arbitrates pattern/RDI/LTSM requests, captures the
// encoded header and payload, hands words to the serializer one at a time
// and inserts an idle gap after every packet or pattern burst.
module sb_tx_packet_framer
  import sb_tx_pkg::*;
#(
  parameter int          PATTERN_ITER = 4,
  parameter int          GAP_CYCLES   = 2,
  parameter logic [63:0] PATTERN_WORD = 64'hAAAA_AAAA_AAAA_AAAA
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  i_state,
  input  logic        i_pattern_req,
  input  logic        i_msg_valid,
  input  logic [3:0]  i_msg_no,
  input  logic [2:0]  i_msg_info,
  input  logic        i_msg_has_data,
  input  logic [15:0] i_data,
  input  logic        i_rdi_valid,
  input  logic [1:0]  i_rdi_msg_code,
  input  logic [3:0]  i_rdi_msg_sub_code,
  input  logic [1:0]  i_rdi_msg_info,
  input  logic        i_ser_done,
  output logic [63:0] o_ser_data,
  output logic        o_ser_valid,
  output logic        o_busy,
  output logic        o_msg_sent,
  output logic        o_rdi_sent,
  output logic        o_pattern_done
);

  localparam int PAT_W = $clog2(PATTERN_ITER + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(PATTERN_ITER - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  sb_tx_state_e     state_q, state_d;
  logic [PAT_W-1:0] pat_cnt_q, pat_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [15:0]      data_q, data_d;
  logic             has_data_q, has_data_d;
  logic             is_rdi_q, is_rdi_d;
  logic [63:0]      ser_data_q, ser_data_d;
  logic             ser_valid_q, ser_valid_d;
  logic             msg_sent_q, msg_sent_d;
  logic             rdi_sent_q, rdi_sent_d;
  logic             pattern_done_q, pattern_done_d;

  logic             enc_has_data;
  logic [7:0]       enc_code;
  logic [7:0]       enc_subcode;
  logic [15:0]      enc_info;
  logic [63:0]      enc_header;
  logic             done_ok;

  // Select RDI or LTSM fields for the encoder; RDI wins when both request
  always_comb begin
    if (i_rdi_valid) begin
      enc_has_data = 1'b0;
      enc_code     = {6'b0, i_rdi_msg_code};
      enc_subcode  = {4'b0, i_rdi_msg_sub_code};
      enc_info     = {14'b0, i_rdi_msg_info};
    end else begin
      enc_has_data = i_msg_has_data;
      enc_code     = SB_MSGCODE_LTSM;
      enc_subcode  = {1'b0, i_state, i_msg_no};
      enc_info     = {13'b0, i_msg_info};
    end
  end

  sb_tx_header_encoder u_header_encoder (
    .i_has_data    (enc_has_data),
    .i_msg_code    (enc_code),
    .i_msg_subcode (enc_subcode),
    .i_msg_info    (enc_info),
    .i_payload     ({48'b0, i_data}),
    .o_header      (enc_header)
  );

  // A done pulse only counts while a word is actually being offered
  assign done_ok = i_ser_done & ser_valid_q;

  // Next-state, capture and registered-output logic
  always_comb begin
    state_d        = state_q;
    pat_cnt_d      = pat_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    data_d         = data_q;
    has_data_d     = has_data_q;
    is_rdi_d       = is_rdi_q;
    ser_data_d     = ser_data_q;
    ser_valid_d    = ser_valid_q;
    msg_sent_d     = 1'b0;
    rdi_sent_d     = 1'b0;
    pattern_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_pattern_req) begin
          state_d     = ST_PATTERN;
          pat_cnt_d   = '0;
          ser_data_d  = PATTERN_WORD;
          ser_valid_d = 1'b1;
        end else if (i_rdi_valid || i_msg_valid) begin
          state_d     = ST_HEADER;
          ser_data_d  = enc_header;
          ser_valid_d = 1'b1;
          data_d      = i_rdi_valid ? 16'h0000 : i_data;
          has_data_d  = enc_has_data;
          is_rdi_d    = i_rdi_valid;
        end
      end

      ST_PATTERN: begin
        if (done_ok) begin
          if (pat_cnt_q == PAT_LAST) begin
            state_d        = ST_GAP;
            gap_cnt_d      = '0;
            ser_data_d     = '0;
            ser_valid_d    = 1'b0;
            pattern_done_d = 1'b1;
          end else begin
            pat_cnt_d = pat_cnt_q + 1'b1;
          end
        end
      end

      ST_HEADER: begin
        if (done_ok) begin
          if (has_data_q) begin
            state_d    = ST_DATA;
            ser_data_d = {48'b0, data_q};
          end else begin
            state_d     = ST_GAP;
            gap_cnt_d   = '0;
            ser_data_d  = '0;
            ser_valid_d = 1'b0;
            msg_sent_d  = 1'b1;
            rdi_sent_d  = is_rdi_q;
          end
        end
      end

      ST_DATA: begin
        if (done_ok) begin
          state_d     = ST_GAP;
          gap_cnt_d   = '0;
          ser_data_d  = '0;
          ser_valid_d = 1'b0;
          msg_sent_d  = 1'b1;
          rdi_sent_d  = is_rdi_q;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        ser_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any packet in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= ST_IDLE;
      pat_cnt_q      <= '0;
      gap_cnt_q      <= '0;
      data_q         <= '0;
      has_data_q     <= 1'b0;
      is_rdi_q       <= 1'b0;
      ser_data_q     <= '0;
      ser_valid_q    <= 1'b0;
      msg_sent_q     <= 1'b0;
      rdi_sent_q     <= 1'b0;
      pattern_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pat_cnt_q      <= pat_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      data_q         <= data_d;
      has_data_q     <= has_data_d;
      is_rdi_q       <= is_rdi_d;
      ser_data_q     <= ser_data_d;
      ser_valid_q    <= ser_valid_d;
      msg_sent_q     <= msg_sent_d;
      rdi_sent_q     <= rdi_sent_d;
      pattern_done_q <= pattern_done_d;
    end
  end

  assign o_ser_data     = ser_data_q;
  assign o_ser_valid    = ser_valid_q;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_msg_sent     = msg_sent_q;
  assign o_rdi_sent     = rdi_sent_q;
  assign o_pattern_done = pattern_done_q;

endmodule

// File: tb/tb_sb_tx_packet_framer.sv
// Self-checking bench for the sideband TX framer. Expected headers come from
// a field-level arithmetic model; protocol timing is checked step by step.
module tb_sb_tx_packet_framer;

  localparam logic [63:0] PAT = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam int GAP = 2;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [2:0]  i_state;
  logic        i_pattern_req;
  logic        i_msg_valid;
  logic [3:0]  i_msg_no;
  logic [2:0]  i_msg_info;
  logic        i_msg_has_data;
  logic [15:0] i_data;
  logic        i_rdi_valid;
  logic [1:0]  i_rdi_msg_code;
  logic [3:0]  i_rdi_msg_sub_code;
  logic [1:0]  i_rdi_msg_info;
  logic        i_ser_done;
  logic [63:0] o_ser_data;
  logic        o_ser_valid;
  logic        o_busy;
  logic        o_msg_sent;
  logic        o_rdi_sent;
  logic        o_pattern_done;

  int checks = 0;
  int failures = 0;

  sb_tx_packet_framer dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_state            (i_state),
    .i_pattern_req      (i_pattern_req),
    .i_msg_valid        (i_msg_valid),
    .i_msg_no           (i_msg_no),
    .i_msg_info         (i_msg_info),
    .i_msg_has_data     (i_msg_has_data),
    .i_data             (i_data),
    .i_rdi_valid        (i_rdi_valid),
    .i_rdi_msg_code     (i_rdi_msg_code),
    .i_rdi_msg_sub_code (i_rdi_msg_sub_code),
    .i_rdi_msg_info     (i_rdi_msg_info),
    .i_ser_done         (i_ser_done),
    .o_ser_data         (o_ser_data),
    .o_ser_valid        (o_ser_valid),
    .o_busy             (o_busy),
    .o_msg_sent         (o_msg_sent),
    .o_rdi_sent         (o_rdi_sent),
    .o_pattern_done     (o_pattern_done)
  );

  initial forever #5 i_clk = ~i_clk;

  // Reference header built from the field rules with plain arithmetic
  function automatic logic [63:0] model_hdr(input bit rdi, input int st, input int no,
                                            input int info, input bit hd, input int d,
                                            input int rc, input int rs, input int ri);
    logic [63:0] h;
    int dp;
    int cp;
    if (rdi) begin
      h  = 64'(18) | (64'(rc) << 14) | (64'(rs) << 32) | (64'(ri) << 40);
      dp = 0;
    end else begin
      h  = 64'(hd ? 27 : 18) | (64'(133) << 14) | (64'(st * 16 + no) << 32) | (64'(info) << 40);
      dp = hd ? ($countones(16'(d)) % 2) : 0;
    end
    cp = ($countones(h) + dp) % 2;
    return h | (64'(cp) << 62) | (64'(dp) << 63);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic pulse_done();
    i_ser_done = 1'b1;
    tick();
    i_ser_done = 1'b0;
  endtask

  // Wait (bounded) for o_ser_valid; n = negedges waited
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!o_ser_valid && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk({tag, "_timeout"}, 64'(o_ser_valid), 64'd1);
  endtask

  // Check the offered word, hold it for 'stall' cycles, then complete it
  task automatic serve(input string tag, input logic [63:0] exp, input int stall, input bit perturb);
    chk({tag, "_valid"}, 64'(o_ser_valid), 64'd1);
    chk({tag, "_data"}, o_ser_data, exp);
    for (int i = 0; i < stall; i++) begin
      if (perturb && i == stall / 2) i_msg_no = i_msg_no + 4'd1;
      tick();
      chk({tag, "_stall_valid"}, 64'(o_ser_valid), 64'd1);
      chk({tag, "_stall_data"}, o_ser_data, exp);
    end
    pulse_done();
  endtask

  task automatic run_packet(input string tag, input logic [63:0] hdr, input bit hd,
                            input logic [15:0] d, input bit rdi, input int stall,
                            input bit perturb, output int n);
    wait_valid(tag, n);
    serve({tag, "_hdr"}, hdr, stall, perturb);
    if (hd) begin
      chk({tag, "_no_early_sent"}, 64'(o_msg_sent), 64'd0);
      serve({tag, "_dword"}, {48'b0, d}, stall, 1'b0);
    end
    chk({tag, "_msg_sent"}, 64'(o_msg_sent), 64'd1);
    chk({tag, "_rdi_sent"}, 64'(o_rdi_sent), 64'(rdi));
    chk({tag, "_valid_low"}, 64'(o_ser_valid), 64'd0);
    if (rdi) i_rdi_valid = 1'b0;
    else     i_msg_valid = 1'b0;
    tick();
    chk({tag, "_sent_pulse"}, 64'(o_msg_sent), 64'd0);
    $display("txn %s hdr=%h data=%0d rdi=%0d", tag, hdr, hd, rdi);
  endtask

  task automatic set_ltsm(input int st, input int no, input int info, input bit hd, input int d);
    i_state        = 3'(st);
    i_msg_no       = 4'(no);
    i_msg_info     = 3'(info);
    i_msg_has_data = hd;
    i_data         = 16'(d);
    i_msg_valid    = 1'b1;
  endtask

  task automatic set_rdi(input int rc, input int rs, input int ri);
    i_rdi_msg_code     = 2'(rc);
    i_rdi_msg_sub_code = 4'(rs);
    i_rdi_msg_info     = 2'(ri);
    i_rdi_valid        = 1'b1;
  endtask

  initial begin
    int n;
    logic [63:0] exp_h;
    i_rst_n = 1'b0; i_state = '0; i_pattern_req = 1'b0; i_msg_valid = 1'b0;
    i_msg_no = '0; i_msg_info = '0; i_msg_has_data = 1'b0; i_data = '0;
    i_rdi_valid = 1'b0; i_rdi_msg_code = '0; i_rdi_msg_sub_code = '0;
    i_rdi_msg_info = '0; i_ser_done = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_valid", 64'(o_ser_valid), 64'd0);
    chk("rst_data", o_ser_data, 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_sent", 64'({o_msg_sent, o_rdi_sent, o_pattern_done}), 64'd0);
    i_rst_n = 1'b1;
    tick();

    // Stray done while idle must be ignored
    pulse_done();
    chk("idle_done_busy", 64'(o_busy), 64'd0);
    chk("idle_done_valid", 64'(o_ser_valid), 64'd0);

    // Pattern burst: 4 words, done every 8 cycles
    i_pattern_req = 1'b1;
    tick();
    i_pattern_req = 1'b0;
    chk("pat_busy", 64'(o_busy), 64'd1);
    for (int k = 0; k < 4; k++) begin
      chk("pat_valid", 64'(o_ser_valid), 64'd1);
      chk("pat_word", o_ser_data, PAT);
      chk("pat_done_early", 64'(o_pattern_done), 64'd0);
      repeat (7) tick();
      pulse_done();
    end
    chk("pat_done_pulse", 64'(o_pattern_done), 64'd1);
    chk("pat_end_valid", 64'(o_ser_valid), 64'd0);
    chk("pat_gap1_busy", 64'(o_busy), 64'd1);
    tick();
    chk("pat_done_once", 64'(o_pattern_done), 64'd0);
    chk("pat_gap2_busy", 64'(o_busy), 64'd1);
    tick();
    chk("pat_idle_busy", 64'(o_busy), 64'd0);
    $display("txn pattern words=4");

    // LTSM, no data
    set_ltsm(3, 5, 2, 1'b0, 0);
    exp_h = model_hdr(1'b0, 3, 5, 2, 1'b0, 0, 0, 0, 0);
    chk("ltsm_nd_model", exp_h, 64'h0000_0235_0021_4012);
    run_packet("ltsm_nd", exp_h, 1'b0, 16'h0, 1'b0, 2, 1'b0, n);
    chk("ltsm_nd_latency", 64'(n), 64'd1);

    // Pattern pulse during the gap is dropped
    i_pattern_req = 1'b1;
    tick();
    i_pattern_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("drop_pat_valid", 64'(o_ser_valid), 64'd0);
      chk("drop_pat_busy", 64'(o_busy), 64'd0);
    end

    // LTSM with data
    set_ltsm(3, 5, 2, 1'b1, 16'hA5C3);
    exp_h = model_hdr(1'b0, 3, 5, 2, 1'b1, 16'hA5C3, 0, 0, 0);
    chk("ltsm_d_model", exp_h, 64'h0000_0235_0021_401B);
    run_packet("ltsm_d", exp_h, 1'b1, 16'hA5C3, 1'b0, 1, 1'b0, n);
    chk("ltsm_d_latency", 64'(n), 64'd1);
    tick();

    // Simultaneous RDI and LTSM: RDI first, LTSM after the gap
    set_ltsm(2, 7, 1, 1'b0, 0);
    set_rdi(1, 9, 2);
    exp_h = model_hdr(1'b1, 0, 0, 0, 1'b0, 0, 1, 9, 2);
    chk("rdi_model", exp_h, 64'h0000_0209_0000_4012);
    run_packet("rdi_first", exp_h, 1'b0, 16'h0, 1'b1, 0, 1'b0, n);
    chk("rdi_latency", 64'(n), 64'd1);
    exp_h = model_hdr(1'b0, 2, 7, 1, 1'b0, 0, 0, 0, 0);
    run_packet("ltsm_after", exp_h, 1'b0, 16'h0, 1'b0, 0, 1'b0, n);
    chk("b2b_gap", 64'(n), 64'(GAP));
    tick();

    // Long stall with i_msg_no changing mid-stall
    set_ltsm(5, 9, 7, 1'b1, 16'h0F31);
    exp_h = model_hdr(1'b0, 5, 9, 7, 1'b1, 16'h0F31, 0, 0, 0);
    run_packet("stall", exp_h, 1'b1, 16'h0F31, 1'b0, 100, 1'b1, n);
    tick();

    // Reset while in DATA
    set_ltsm(1, 2, 3, 1'b1, 16'h1234);
    exp_h = model_hdr(1'b0, 1, 2, 3, 1'b1, 16'h1234, 0, 0, 0);
    wait_valid("rst_pkt", n);
    serve("rst_pkt_hdr", exp_h, 2, 1'b0);
    chk("rst_pkt_dword", o_ser_data, 64'h0000_0000_0000_1234);
    #2 i_rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(o_ser_valid), 64'd0);
    chk("midrst_data", o_ser_data, 64'd0);
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_sent", 64'({o_msg_sent, o_rdi_sent, o_pattern_done}), 64'd0);
    i_msg_valid = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();
    chk("postrst_busy", 64'(o_busy), 64'd0);
    chk("postrst_sent", 64'(o_msg_sent), 64'd0);
    $display("txn reset_in_data");
    set_rdi(3, 4'hC, 1);
    exp_h = model_hdr(1'b1, 0, 0, 0, 1'b0, 0, 3, 12, 1);
    run_packet("postrst_rdi", exp_h, 1'b0, 16'h0, 1'b1, 1, 1'b0, n);
    chk("postrst_latency", 64'(n), 64'd1);
    tick();

    // Randomized LTSM / RDI packets
    for (int r = 0; r < 12; r++) begin
      bit rdi;
      bit hd;
      int st, no, inf, d, rc, rs, ri, stall;
      rdi = 1'($urandom_range(0, 1));
      hd  = 1'($urandom_range(0, 1));
      st = $urandom_range(0, 7);  no = $urandom_range(0, 15); inf = $urandom_range(0, 7);
      d  = $urandom_range(0, 65535);
      rc = $urandom_range(0, 3);  rs = $urandom_range(0, 15); ri = $urandom_range(0, 3);
      stall = $urandom_range(0, 3);
      if (rdi) begin
        set_rdi(rc, rs, ri);
        exp_h = model_hdr(1'b1, 0, 0, 0, 1'b0, 0, rc, rs, ri);
        run_packet("rand_rdi", exp_h, 1'b0, 16'h0, 1'b1, stall, 1'b0, n);
      end else begin
        set_ltsm(st, no, inf, hd, d);
        exp_h = model_hdr(1'b0, st, no, inf, hd, d, 0, 0, 0);
        run_packet("rand_ltsm", exp_h, hd, 16'(d), 1'b0, stall, 1'b0, n);
      end
      chk("rand_latency", 64'(n), 64'd1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
